// File: rtl/riscv_pkg.sv
// Shared types for the MEM-stage load/store unit: control bundle, FSM states,
// funct3 encodings and the alignment rule.
package riscv_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } ctrl_signals_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RVALID,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Store encodings alias the signed loads, so one rule covers both.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_LH, F3_LHU: return offset[0];
            F3_LW:         return offset != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        data = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, byte_lane};
            F3_LHU:  data = {16'h0, half_lane};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues one req/gnt/rvalid bus transaction per
// aligned memory op, stalls the pipeline until it completes, and times out hung accesses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  ctrl_signals_t ctrl_in,
    input  logic [31:0]   alu_result_in,
    input  logic [31:0]   store_data_in,
    output logic          stall_out,
    output logic [31:0]   mem_data_out,
    output logic          misaligned_out,
    output logic          bus_err_out,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [31:0]   dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [31:0]   dmem_rdata
);

    // Headroom for the counter to run one past the limit while leaving WAIT_RVALID.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic             mem_op, misaligned, issue, timed_out, load_done, fire_err;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next, load_data;

    assign mem_op         = valid_in & (ctrl_in.mem_read | ctrl_in.mem_write);
    assign misaligned     = is_misaligned(ctrl_in.funct3, alu_result_in[1:0]);
    assign misaligned_out = mem_op & misaligned;
    assign issue          = mem_op & ~misaligned;
    assign timed_out      = cnt >= CNT_LAST;
    assign dmem_req       = (state == REQ);

    always_comb begin
        be_next    = 4'hF;
        wdata_next = store_data_in;
        case (ctrl_in.funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << alu_result_in[1:0];
                wdata_next = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << alu_result_in[1:0];
                wdata_next = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Bus completion wins over a timeout that lands in the same cycle.
    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        load_done  = 1'b0;
        fire_err   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stall_out  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (dmem_gnt) begin
                    state_next = dmem_we ? DONE : WAIT_RVALID;
                end else if (timed_out) begin
                    state_next = DONE;
                    fire_err   = 1'b1;
                end
            end
            WAIT_RVALID: begin
                stall_out = 1'b1;
                if (dmem_rvalid) begin
                    state_next = DONE;
                    load_done  = 1'b1;
                end else if (timed_out) begin
                    state_next = DONE;
                    fire_err   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            mem_data_out <= '0;
            bus_err_out  <= 1'b0;
        end else begin
            bus_err_out <= fire_err;
            if (state == IDLE && issue) begin
                cnt        <= '0;
                dmem_we    <= ctrl_in.mem_write;
                dmem_addr  <= {alu_result_in[31:2], 2'b00};
                dmem_be    <= be_next;
                dmem_wdata <= wdata_next;
                funct3_q   <= ctrl_in.funct3;
                offset_q   <= alu_result_in[1:0];
            end else if (state == REQ || state == WAIT_RVALID) begin
                cnt <= cnt + 1'b1;
            end
            if (load_done) begin
                mem_data_out <= load_data;
            end else if (fire_err) begin
                mem_data_out <= '0;
            end
        end
    end

    lsu_load_align u_align (
        .funct3 (funct3_q),
        .offset (offset_q),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random ops, all
// compared against a transaction-level model of latency, lanes and results.
module tb_load_store_unit;
    import riscv_pkg::*;

    localparam int T = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    ctrl_signals_t ctrl_in;
    logic [31:0]   alu_result_in, store_data_in;
    logic          stall_out, misaligned_out, bus_err_out;
    logic [31:0]   mem_data_out;
    logic          dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_be;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_mem  = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ctrl_in        (ctrl_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .stall_out      (stall_out),
        .mem_data_out   (mem_data_out),
        .misaligned_out (misaligned_out),
        .bus_err_out    (bus_err_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b001 || f3 == 3'b101) return (addr % 2) != 0;
        if (f3 == 3'b010)                 return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned sh = 8 * (addr % 4);
        logic [31:0] b  = (word >> sh) & 32'hFF;
        logic [31:0] h  = (word >> sh) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b010:  return word;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = access_bytes(f3);
        int mask = ((1 << n) - 1) << (addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = access_bytes(f3);
        logic [31:0] w = '0;
        for (int lane = 0; lane < 4; lane++)
            w = w | (((d >> (8 * (lane % n))) & 32'hFF) << (8 * lane));
        return w;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in    = 1'b0;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            #1;
            check("idle stall", 32'(stall_out), 32'd0);
            check("idle req", 32'(dmem_req), 32'd0);
            check("idle bus_err", 32'(bus_err_out), 32'd0);
            check("idle mem_data hold", mem_data_out, exp_mem);
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic non_mem_op(input logic [31:0] addr);
        @(negedge clk);
        valid_in           = 1'b1;
        ctrl_in.mem_read   = 1'b0;
        ctrl_in.mem_write  = 1'b0;
        ctrl_in.funct3     = 3'($urandom_range(0, 7));
        alu_result_in      = addr;
        #1;
        check("nonmem stall", 32'(stall_out), 32'd0);
        check("nonmem misaligned", 32'(misaligned_out), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        check("nonmem req", 32'(dmem_req), 32'd0);
    endtask

    // One instruction from issue to DONE. g = REQ cycles before gnt, r = WAIT
    // cycles before rvalid (large r = never).
    task automatic run_op(input string tag, input bit is_load, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] word, input int g, input int r);
        bit mis = ref_misaligned(f3, addr);
        bit exp_err = 1'b0;
        int exp_stalls = 0, exp_reqs = 0, exp_hs = 0, c;
        int stalls = 0, reqs = 0, waits = 0, hs = 0;
        bit granted = 1'b0, finished = 1'b0;

        if (!mis) begin
            c          = is_load ? g + 1 + r : g;
            exp_err    = c > T - 1;
            exp_reqs   = ((g < T - 1) ? g : T - 1) + 1;
            exp_hs     = (g <= T - 1) ? 1 : 0;
            exp_stalls = 1 + (exp_err ? T : c + 1);
            if (is_load) exp_mem = exp_err ? 32'h0 : ref_load(f3, addr, word);
        end

        @(negedge clk);
        valid_in          = 1'b1;
        ctrl_in.mem_read  = is_load;
        ctrl_in.mem_write = !is_load;
        ctrl_in.funct3    = f3;
        alu_result_in     = addr;
        store_data_in     = sdata;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (dmem_req) begin
                if (reqs == g) begin
                    dmem_gnt = 1'b1;
                    hs++;
                end else begin
                    dmem_rvalid = 1'($urandom_range(0, 1));
                end
                reqs++;
            end else if (granted && is_load) begin
                if (waits == r) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = word;
                end
                waits++;
            end
            #1;
            if (cyc == 0) check({tag, " misaligned"}, 32'(misaligned_out), 32'(mis));
            if (dmem_gnt) begin
                granted = 1'b1;
                check({tag, " addr"}, dmem_addr, addr - (addr % 4));
                check({tag, " we"}, 32'(dmem_we), 32'(!is_load));
                if (!is_load) begin
                    check({tag, " be"}, 32'(dmem_be), 32'(ref_be(f3, addr)));
                    check({tag, " wdata"}, dmem_wdata, ref_wdata(f3, sdata));
                end
            end
            if (stall_out) stalls++;
            else finished = 1'b1;
        end
        check({tag, " completed"}, 32'(finished), 32'd1);
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " req cycles"}, 32'(reqs), 32'(exp_reqs));
        check({tag, " handshakes"}, 32'(hs), 32'(exp_hs));
        check({tag, " bus_err"}, 32'(bus_err_out), 32'(exp_err));
        check({tag, " mem_data"}, mem_data_out, exp_mem);
        check({tag, " req low at end"}, 32'(dmem_req), 32'd0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (mis) begin
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check({tag, " no req after misaligned"}, 32'(dmem_req), 32'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0]  load_f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          is_load;

        rst           = 1'b1;
        valid_in      = 1'b0;
        ctrl_in       = '0;
        alu_result_in = '0;
        store_data_in = '0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = '0;
        #1;
        check("reset req", 32'(dmem_req), 32'd0);
        check("reset we", 32'(dmem_we), 32'd0);
        check("reset addr", dmem_addr, 32'd0);
        check("reset be", 32'(dmem_be), 32'd0);
        check("reset wdata", dmem_wdata, 32'd0);
        check("reset mem_data", mem_data_out, 32'd0);
        check("reset bus_err", 32'(bus_err_out), 32'd0);
        check("reset stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("LW 0x100", 1, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_op("LB 0x103", 1, F3_LB, 32'h103, 32'h0, 32'h80123456, 0, 0);
        run_op("LBU 0x103", 1, F3_LBU, 32'h103, 32'h0, 32'h80123456, 0, 0);
        run_op("LHU 0x102", 1, F3_LHU, 32'h102, 32'h0, 32'hBEEF1234, 0, 0);
        run_op("SH 0x202", 0, F3_SH, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
        run_op("LW 0x101", 1, F3_LW, 32'h101, 32'h0, 32'h0, 0, 0);
        run_op("SB 0x003", 0, F3_SB, 32'h003, 32'h5A5A5AC3, 32'h0, 0, 0);
        run_op("LH 0x002", 1, F3_LH, 32'h002, 32'h0, 32'h9ABC0000, 1, 2);
        run_op("LD f3=011", 1, 3'b011, 32'h010, 32'h0, 32'hFFFFFFFF, 0, 0);
        idle(1);

        // Hung load: no rvalid ever, then a late rvalid after DONE.
        run_op("LW timeout", 1, F3_LW, 32'h400, 32'h0, 32'h11111111, 0, 1000);
        @(negedge clk);
        valid_in    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        #1;
        check("timeout bus_err clears", 32'(bus_err_out), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("late rvalid ignored", mem_data_out, 32'h0);
        check("late rvalid no stall", 32'(stall_out), 32'd0);

        // Reset pulse while waiting for rvalid.
        run_op("LW pre-reset", 1, F3_LW, 32'h104, 32'h0, 32'h01020304, 0, 0);
        @(negedge clk);
        valid_in          = 1'b1;
        ctrl_in.mem_read  = 1'b1;
        ctrl_in.mem_write = 1'b0;
        ctrl_in.funct3    = F3_LW;
        alu_result_in     = 32'h300;
        @(negedge clk);
        #1;
        check("rst: req before gnt", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rst: stalled in wait", 32'(stall_out), 32'd1);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        #1;
        exp_mem = 32'h0;
        check("rst: req", 32'(dmem_req), 32'd0);
        check("rst: stall", 32'(stall_out), 32'd0);
        check("rst: mem_data", mem_data_out, 32'h0);
        check("rst: addr", dmem_addr, 32'h0);
        check("rst: be", 32'(dmem_be), 32'd0);
        check("rst: bus_err", 32'(bus_err_out), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("rst: stale rvalid ignored", mem_data_out, 32'h0);
        run_op("LW post-reset", 1, F3_LW, 32'h300, 32'h0, 32'h76543210, 0, 1);

        // Back-to-back store then load with no gap.
        run_op("SW b2b", 0, F3_SW, 32'h500, 32'hA5A5F00F, 32'h0, 1, 0);
        run_op("LW b2b", 1, F3_LW, 32'h500, 32'h0, 32'hA5A5F00F, 0, 0);
        non_mem_op(32'h123);

        for (int i = 0; i < 60; i++) begin
            is_load = 1'($urandom_range(0, 1));
            f3 = is_load ? load_f3s[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
            addr = $urandom_range(0, 32'hFFFF);
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % access_bytes(f3));
            run_op("rand", is_load, f3, addr, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: idle(1);
                1: non_mem_op($urandom);
                default: ;
            endcase
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
